check_password: RTL and testbench
=================================

Name: check_password

Overview:
Reader side of the password store. Collects a 4-digit entry from the keypad strobe stream and compares it digit-by-digit against the stored pwd0..pwd3 words. Reports unlock or fail, counts consecutive failures and enforces a timed lockout. Sits beside set_password, shares the keypad bus (keyValue/enable), and is selected by its own mode line (check).

Parameters:
- PWD_LEN, 4, digits per entry; fixed to match the four stored words.
- MAX_FAIL, 3, consecutive failures that trigger lockout.
- UNLOCK_CYCLES, 16, clk cycles unlock stays high.
- LOCK_CYCLES, 64, clk cycles locked stays high.

Ports:
- clk  in  1  single clock; all state on posedge clk.
- rst  in  1  asynchronous, active-high reset.
- keyValue  in  4  keypad digit, valid when enable=1.
- enable  in  1  one-cycle key strobe.
- check  in  1  check-mode select; entry is accepted only while high.
- pwd0..pwd3  in  4 each  stored password, with pwd0 the first digit.
- unlock  out  1  high in OPEN.
- fail  out  1  one-cycle pulse on a wrong entry.
- locked  out  1  high in LOCK.
- digitCount  out  3  digits captured in the current entry, 0..4.
- failCount  out  $clog2(MAX_FAIL+1)  consecutive failures.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high on rst; it is fixed for this block.
- Reset forces state IDLE, with unlock=0, fail=0, locked=0, digitCount=0, failCount=0, mismatch flag=0 and timer=0. This applies at any point, including mid-entry and mid-lockout.
- Key accepted = check & enable, sampled on posedge clk. Only IDLE and ENTRY accept keys.
- Per-digit compare: at each accepted key, keyValue is compared with the pwd word at index digitCount, sampled at that edge.
  - A mismatch sets a sticky mismatch flag.
  - There is no early reject: all PWD_LEN digits are always collected.
- IDLE:
  - An accepted key captures digit 0, sets digitCount=1 and moves to ENTRY.
  - Otherwise the state holds.
- ENTRY:
  - An accepted key increments digitCount.
  - On the edge that accepts digit PWD_LEN-1 (the 4th), the next state is decided using the flag including that digit: OPEN if no mismatch, else DENY. unlock/fail are therefore visible one cycle after the 4th strobe.
  - check=0 in ENTRY aborts to IDLE: digitCount=0, flag cleared, failCount unchanged, no fail pulse.
- OPEN:
  - unlock=1; timer loads UNLOCK_CYCLES-1 on entry; failCount=0 on entry.
  - Keys are ignored. At timer=0 the block goes to IDLE; unlock is high for exactly UNLOCK_CYCLES cycles.
- DENY (one cycle):
  - fail=1 and failCount increments.
  - If the new failCount equals MAX_FAIL, go to LOCK; otherwise go to IDLE.
  - digitCount and flag are cleared on leaving ENTRY.
- LOCK:
  - locked=1 for exactly LOCK_CYCLES cycles; keys are ignored, including check&enable.
  - Then go to IDLE with failCount=0.
- digitCount returns to 0 on any exit from ENTRY.
- failCount saturates at MAX_FAIL and never wraps.
- Simultaneous check&enable on the exit cycle of OPEN or LOCK is ignored; the first key is accepted in IDLE on the next cycle.
- pwd inputs changing mid-entry: already-compared digits keep their result, and later digits use the new values.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, ENTRY, OPEN, DENY, LOCK);
  - PWD_LEN=4 and DIGIT_W=4, shared with set_password.
- One natural sub-module: hold_timer, a loadable down-counter with a zero flag, reused for the OPEN and LOCK durations. Width is $clog2 of the max of UNLOCK_CYCLES and LOCK_CYCLES.

Test Plan:
1. Store 1,2,3,4 (pwd0..pwd3); check=1; strobe 1,2,3,4 on consecutive cycles.
   -> unlock=1 from the cycle after the 4th strobe for 16 cycles; fail never set; failCount=0.
2. Store 1,2,3,4; strobe 1,9,3,4.
   -> no response until the 4th strobe; then fail pulses one cycle; failCount=1; unlock stays 0.
3. Three wrong entries back to back.
   -> failCount goes 1, 2, 3; locked=1 for 64 cycles; keys during LOCK have no effect; then IDLE with failCount=0; a correct entry then unlocks.
4. Two digits entered, then check=0.
   -> IDLE with digitCount=0 and no fail; a following correct full entry unlocks.
5. rst pulsed high mid-entry (digitCount=2) and mid-LOCK.
   -> all outputs 0 immediately (asynchronous); a subsequent correct entry unlocks.
6. Two failures, then a correct entry.
   -> unlock, failCount=0; a subsequent wrong entry gives failCount=1 (no lockout).

Source files
------------

// File: rtl/check_password_pkg.sv
// Shared definitions for the password reader/writer pair: FSM encoding,
// entry geometry and the stored-digit selector.
package check_password_pkg;

  localparam int PWD_LEN = 4;
  localparam int DIGIT_W = 4;

  localparam logic [2:0] LAST_DIGIT = 3'(PWD_LEN - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ENTRY = 3'd1;
  localparam logic [2:0] ST_OPEN  = 3'd2;
  localparam logic [2:0] ST_DENY  = 3'd3;
  localparam logic [2:0] ST_LOCK  = 3'd4;

  function automatic logic [DIGIT_W-1:0] pick_digit(
    input logic [2:0]         idx,
    input logic [DIGIT_W-1:0] p0,
    input logic [DIGIT_W-1:0] p1,
    input logic [DIGIT_W-1:0] p2,
    input logic [DIGIT_W-1:0] p3
  );
    logic [DIGIT_W-1:0] d;
    case (idx)
      3'd0:    d = p0;
      3'd1:    d = p1;
      3'd2:    d = p2;
      3'd3:    d = p3;
      default: d = {DIGIT_W{1'b0}};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/check_password_hold_timer.sv
// Loadable down-counter with a zero flag; times the OPEN and LOCK windows.
module hold_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_r;

  // Load wins over counting; the counter parks at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != {W{1'b0}}) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/check_password.sv
// Keypad password checker: collects a full entry, compares it digit by digit
// against the stored words, and drives unlock/fail with a timed lockout.
module check_password
  import check_password_pkg::*;
#(
  parameter int MAX_FAIL      = 3,
  parameter int UNLOCK_CYCLES = 16,
  parameter int LOCK_CYCLES   = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DIGIT_W-1:0]              keyValue,
  input  logic                            enable,
  input  logic                            check,
  input  logic [DIGIT_W-1:0]              pwd0,
  input  logic [DIGIT_W-1:0]              pwd1,
  input  logic [DIGIT_W-1:0]              pwd2,
  input  logic [DIGIT_W-1:0]              pwd3,
  output logic                            unlock,
  output logic                            fail,
  output logic                            locked,
  output logic [2:0]                      digitCount,
  output logic [$clog2(MAX_FAIL+1)-1:0]   failCount
);

  localparam int FAIL_W    = $clog2(MAX_FAIL + 1);
  localparam int TIMER_MAX = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX);

  localparam logic [FAIL_W-1:0]  FAIL_LIMIT = FAIL_W'(MAX_FAIL);
  localparam logic [FAIL_W-1:0]  FAIL_ONE   = FAIL_W'(1);
  localparam logic [TIMER_W-1:0] OPEN_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LOAD  = TIMER_W'(LOCK_CYCLES - 1);

  logic [2:0]         state_r, state_s;
  logic               mism_r, mism_s;
  logic [2:0]         digit_s;
  logic [FAIL_W-1:0]  fail_cnt_s;
  logic               key_s, digit_bad_s;
  logic               tmr_load_s, tmr_zero_s;
  logic [TIMER_W-1:0] tmr_val_s;

  hold_timer #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load_s),
    .load_value (tmr_val_s),
    .zero       (tmr_zero_s)
  );

  // Next-state and bookkeeping decisions for the entry FSM.
  always_comb begin
    key_s       = check & enable;
    digit_bad_s = (keyValue != pick_digit(digitCount, pwd0, pwd1, pwd2, pwd3));
    state_s     = state_r;
    mism_s      = mism_r;
    digit_s     = digitCount;
    fail_cnt_s  = failCount;
    tmr_load_s  = 1'b0;
    tmr_val_s   = {TIMER_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (key_s) begin
          state_s = ST_ENTRY;
          digit_s = 3'd1;
          mism_s  = digit_bad_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ENTRY: begin
        if (!check) begin
          state_s = ST_IDLE;
          digit_s = 3'd0;
          mism_s  = 1'b0;
        end else if (enable) begin
          if (digitCount == LAST_DIGIT) begin
            // The last digit's own compare must take part in the verdict.
            digit_s = 3'd0;
            mism_s  = 1'b0;
            if (mism_r | digit_bad_s) begin
              state_s = ST_DENY;
              if (failCount < FAIL_LIMIT) begin
                fail_cnt_s = failCount + FAIL_ONE;
              end else begin
                fail_cnt_s = failCount;
              end
            end else begin
              state_s    = ST_OPEN;
              fail_cnt_s = {FAIL_W{1'b0}};
              tmr_load_s = 1'b1;
              tmr_val_s  = OPEN_LOAD;
            end
          end else begin
            digit_s = digitCount + 3'd1;
            mism_s  = mism_r | digit_bad_s;
          end
        end else begin
          state_s = ST_ENTRY;
        end
      end
      ST_OPEN: begin
        if (tmr_zero_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_OPEN;
        end
      end
      ST_DENY: begin
        if (failCount == FAIL_LIMIT) begin
          state_s    = ST_LOCK;
          tmr_load_s = 1'b1;
          tmr_val_s  = LOCK_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOCK: begin
        if (tmr_zero_s) begin
          state_s    = ST_IDLE;
          fail_cnt_s = {FAIL_W{1'b0}};
        end else begin
          state_s = ST_LOCK;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        digit_s    = 3'd0;
        mism_s     = 1'b0;
        fail_cnt_s = {FAIL_W{1'b0}};
      end
    endcase
  end

  // State and registered outputs; flags are decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      mism_r     <= 1'b0;
      digitCount <= 3'd0;
      failCount  <= {FAIL_W{1'b0}};
      unlock     <= 1'b0;
      fail       <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state_r    <= state_s;
      mism_r     <= mism_s;
      digitCount <= digit_s;
      failCount  <= fail_cnt_s;
      unlock     <= (state_s == ST_OPEN);
      fail       <= (state_s == ST_DENY);
      locked     <= (state_s == ST_LOCK);
    end
  end

endmodule

// File: tb/tb_check_password.sv
// Directed self-checking bench for check_password.
module tb_check_password;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] keyValue = 4'd0;
  logic       enable = 1'b0;
  logic       check = 1'b1;
  logic [3:0] pwd0 = 4'd1, pwd1 = 4'd2, pwd2 = 4'd3, pwd3 = 4'd4;
  logic       unlock, fail, locked;
  logic [2:0] digitCount;
  logic [1:0] failCount;

  int checks = 0;
  int failures = 0;

  check_password dut (
    .clk(clk), .rst(rst), .keyValue(keyValue), .enable(enable), .check(check),
    .pwd0(pwd0), .pwd1(pwd1), .pwd2(pwd2), .pwd3(pwd3),
    .unlock(unlock), .fail(fail), .locked(locked),
    .digitCount(digitCount), .failCount(failCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; returns on the negedge after the capturing posedge.
  task automatic press(input logic [3:0] d);
    keyValue = d;
    enable   = 1'b1;
    @(negedge clk);
    enable   = 1'b0;
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((unlock || locked) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {7'd0, (n < 200)}, 8'd1);
  endtask

  int  cnt;
  logic seen_fail;
  logic key_moved;

  initial begin
    #2;
    chk("rst_unlock", {7'd0, unlock}, 8'd0);
    chk("rst_fail",   {7'd0, fail},   8'd0);
    chk("rst_locked", {7'd0, locked}, 8'd0);
    chk("rst_digits", {5'd0, digitCount}, 8'd0);
    chk("rst_fcnt",   {6'd0, failCount},  8'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: correct entry opens for 16 cycles
    press(4'd1); chk("t1_dc1", {5'd0, digitCount}, 8'd1);
    press(4'd2); chk("t1_dc2", {5'd0, digitCount}, 8'd2);
    press(4'd3); chk("t1_dc3", {5'd0, digitCount}, 8'd3);
    chk("t1_no_early_unlock", {7'd0, unlock}, 8'd0);
    press(4'd4);
    chk("t1_unlock", {7'd0, unlock}, 8'd1);
    chk("t1_dc0",    {5'd0, digitCount}, 8'd0);
    cnt = 0; seen_fail = 1'b0;
    while (unlock && cnt < 100) begin
      cnt++;
      if (fail) seen_fail = 1'b1;
      @(negedge clk);
    end
    chk("t1_unlock_len", 8'(cnt), 8'd16);
    chk("t1_no_fail", {7'd0, seen_fail}, 8'd0);
    chk("t1_fcnt", {6'd0, failCount}, 8'd0);

    // 2: wrong second digit, verdict only after the 4th
    press(4'd1); press(4'd9); press(4'd3);
    chk("t2_no_early_fail", {7'd0, fail}, 8'd0);
    chk("t2_dc3", {5'd0, digitCount}, 8'd3);
    press(4'd4);
    chk("t2_fail", {7'd0, fail}, 8'd1);
    chk("t2_fcnt", {6'd0, failCount}, 8'd1);
    chk("t2_unlock", {7'd0, unlock}, 8'd0);
    @(negedge clk);
    chk("t2_fail_pulse", {7'd0, fail}, 8'd0);
    chk("t2_fcnt_hold", {6'd0, failCount}, 8'd1);

    // 3: two more failures lock for 64 cycles
    enter4(4'd5, 4'd5, 4'd5, 4'd5);
    chk("t3_fcnt2", {6'd0, failCount}, 8'd2);
    @(negedge clk);
    enter4(4'd1, 4'd2, 4'd3, 4'd5);
    chk("t3_fcnt3", {6'd0, failCount}, 8'd3);
    chk("t3_fail3", {7'd0, fail}, 8'd1);
    chk("t3_not_yet_locked", {7'd0, locked}, 8'd0);
    @(negedge clk);
    cnt = 0; key_moved = 1'b0;
    while (locked && cnt < 200) begin
      cnt++;
      if (digitCount != 3'd0 || unlock) key_moved = 1'b1;
      keyValue = 4'd1;
      enable   = 1'b1;
      @(negedge clk);
    end
    enable = 1'b0;
    chk("t3_lock_len", 8'(cnt), 8'd64);
    chk("t3_keys_ignored", {7'd0, key_moved}, 8'd0);
    chk("t3_exit_key_ignored", {5'd0, digitCount}, 8'd0);
    chk("t3_fcnt_cleared", {6'd0, failCount}, 8'd0);
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    chk("t3_unlock_after", {7'd0, unlock}, 8'd1);
    wait_idle("t3_idle");

    // 4: abort mid-entry keeps failCount, then correct entry
    enter4(4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    press(4'd1); press(4'd2);
    chk("t4_dc2", {5'd0, digitCount}, 8'd2);
    check = 1'b0;
    @(negedge clk);
    chk("t4_abort_dc", {5'd0, digitCount}, 8'd0);
    chk("t4_abort_nofail", {7'd0, fail}, 8'd0);
    chk("t4_abort_fcnt", {6'd0, failCount}, 8'd1);
    check = 1'b1;
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    chk("t4_unlock", {7'd0, unlock}, 8'd1);
    chk("t4_fcnt0", {6'd0, failCount}, 8'd0);
    wait_idle("t4_idle");

    // 5: asynchronous reset mid-entry and mid-lock
    press(4'd1); press(4'd2);
    chk("t5_dc2", {5'd0, digitCount}, 8'd2);
    #2 rst = 1'b1;
    #1 chk("t5_rst_dc", {5'd0, digitCount}, 8'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    enter4(4'd9, 4'd9, 4'd9, 4'd9); @(negedge clk);
    enter4(4'd9, 4'd9, 4'd9, 4'd9); @(negedge clk);
    enter4(4'd9, 4'd9, 4'd9, 4'd9); @(negedge clk);
    repeat (5) @(negedge clk);
    chk("t5_locked", {7'd0, locked}, 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_locked", {7'd0, locked}, 8'd0);
    chk("t5_rst_fcnt", {6'd0, failCount}, 8'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    chk("t5_unlock", {7'd0, unlock}, 8'd1);
    wait_idle("t5_idle");

    // 6: two failures, success clears count, next failure restarts at 1
    enter4(4'd4, 4'd3, 4'd2, 4'd1); @(negedge clk);
    enter4(4'd4, 4'd3, 4'd2, 4'd1); @(negedge clk);
    chk("t6_fcnt2", {6'd0, failCount}, 8'd2);
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    chk("t6_unlock", {7'd0, unlock}, 8'd1);
    chk("t6_fcnt0", {6'd0, failCount}, 8'd0);
    wait_idle("t6_idle");
    enter4(4'd1, 4'd2, 4'd3, 4'd3);
    chk("t6_fail", {7'd0, fail}, 8'd1);
    chk("t6_fcnt1", {6'd0, failCount}, 8'd1);
    @(negedge clk);
    @(negedge clk);
    chk("t6_no_lock", {7'd0, locked}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
